// File: rtl/axis_skid_buffer.sv
// Two-entry AXI4-Stream register slice: OUT holds the beat on the bus, SKID catches
// the one extra beat accepted in the cycle after downstream stalls.
module axis_skid_buffer #(
  parameter int DATA_W = 32,
  parameter int USER_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [USER_W-1:0] s_axis_tuser,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [USER_W-1:0] m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [USER_W-1:0] user;
    logic              last;
  } beat_t;

  // Encoding is {OUT.valid, SKID.valid}, so the valids come straight off state_q.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b10,
    FULL  = 2'b11
  } state_e;

  // Handshake rule on both sides: a beat transfers on a rising edge where
  // tvalid && tready are both high; tvalid never waits on tready.
  state_e state_q, state_d;
  beat_t  out_q, out_d;
  beat_t  skid_q, skid_d;
  logic   s_ready_q, s_ready_d;
  beat_t  in_beat;
  logic   s_hs, m_hs;

  assign in_beat = '{data: s_axis_tdata, user: s_axis_tuser, last: s_axis_tlast};
  assign s_hs    = s_axis_tvalid && s_ready_q;
  assign m_hs    = state_q[1] && m_axis_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      out_q     <= '0;
      skid_q    <= '0;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      skid_q    <= skid_d;
      s_ready_q <= s_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (s_hs) begin
          out_d   = in_beat;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (s_hs && m_hs) begin
          out_d = in_beat;
        end else if (s_hs) begin
          skid_d  = in_beat;
          state_d = FULL;
        end else if (m_hs) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // SKID is always the younger beat, so it moves into OUT on drain.
        if (m_hs) begin
          out_d   = skid_q;
          skid_d  = '0;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    s_ready_d = (state_d != FULL);
  end

  assign s_axis_tready = s_ready_q;
  assign m_axis_tvalid = state_q[1];
  assign m_axis_tdata  = out_q.data;
  assign m_axis_tuser  = out_q.user;
  assign m_axis_tlast  = out_q.last;

endmodule

// File: tb/tb_axis_skid_buffer.sv
// Bench for axis_skid_buffer: directed steps plus random traffic, checked against a
// queue model holding at most two in-flight beats.
module tb_axis_skid_buffer;

  localparam int DATA_W = 32;
  localparam int USER_W = 1;
  localparam int BEAT_W = DATA_W + USER_W + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] s_tdata = '0;
  logic [USER_W-1:0] s_tuser = '0;
  logic              s_tlast = 1'b0;
  logic              s_tvalid = 1'b0;
  logic              s_tready;
  logic [DATA_W-1:0] m_tdata;
  logic [USER_W-1:0] m_tuser;
  logic              m_tlast;
  logic              m_tvalid;
  logic              m_tready = 1'b0;

  axis_skid_buffer #(.DATA_W(DATA_W), .USER_W(USER_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tuser  (s_tuser),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  logic [BEAT_W-1:0] exp_q[$];
  logic              exp_ready = 1'b0;
  int                n_checks = 0;
  int                n_fails = 0;
  int                acc_cnt = 0;
  int                out_cnt = 0;
  bit                last_s_hs = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [BEAT_W-1:0] obs_beat;
    chk("s_tready", 64'(s_tready), 64'(exp_ready));
    chk("m_tvalid", 64'(m_tvalid), 64'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      obs_beat = {m_tdata, m_tuser, m_tlast};
      chk("m_beat", 64'(obs_beat), 64'(exp_q[0]));
    end
  endtask

  // One clock: decide handshakes from the model's view, advance the model, check.
  task automatic step();
    bit s_hs, m_hs;
    s_hs = s_tvalid && exp_ready && !rst;
    m_hs = (exp_q.size() > 0) && m_tready && !rst;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      exp_ready = 1'b0;
      last_s_hs = 1'b0;
    end else begin
      if (m_hs) begin
        void'(exp_q.pop_front());
        out_cnt++;
      end
      if (s_hs) begin
        exp_q.push_back({s_tdata, s_tuser, s_tlast});
        acc_cnt++;
      end
      exp_ready = (exp_q.size() < 2);
      last_s_hs = s_hs;
    end
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d,
                       input logic [USER_W-1:0] u, input logic l);
    s_tvalid = v;
    s_tdata  = d;
    s_tuser  = u;
    s_tlast  = l;
  endtask

  initial begin
    int cycles;
    int base_acc, base_out;

    // reset held for two cycles
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_tdata", 64'(m_tdata), 64'h0);
    end
    rst = 1'b0;
    step();
    chk("rel_tready", 64'(s_tready), 64'h1);

    // stall capture
    m_tready = 1'b0;
    drive(1'b1, 32'hDEADBEEF, '0, 1'b0);
    for (int i = 0; i < 3; i++) step();
    chk("stall_acc", 64'(acc_cnt), 64'd2);
    chk("stall_tready", 64'(s_tready), 64'h0);
    chk("stall_tdata", 64'(m_tdata), 64'hDEADBEEF);
    chk("stall_tvalid", 64'(m_tvalid), 64'h1);

    // stall release
    m_tready = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    step();
    chk("rel1_tready", 64'(s_tready), 64'h1);
    chk("rel1_tdata", 64'(m_tdata), 64'hDEADBEEF);
    step();
    chk("rel2_tvalid", 64'(m_tvalid), 64'h0);
    chk("rel_out", 64'(out_cnt), 64'd2);

    // streaming 1..16 back-to-back
    base_out = out_cnt;
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, DATA_W'(i), '0, (i == 16));
      step();
      chk("stream_tdata", 64'(m_tdata), 64'(i));
      chk("stream_tlast", 64'(m_tlast), 64'(i == 16));
    end
    drive(1'b0, '0, '0, 1'b0);
    step();
    chk("stream_out", 64'(out_cnt - base_out), 64'd16);
    chk("stream_tvalid", 64'(m_tvalid), 64'h0);

    // random traffic; tvalid held with stable payload until accepted
    base_acc = acc_cnt;
    base_out = out_cnt;
    cycles = 0;
    while (((acc_cnt - base_acc) < 1000 || exp_q.size() > 0) && cycles < 20000) begin
      if (!s_tvalid || last_s_hs) begin
        if ((acc_cnt - base_acc) < 1000 && $urandom_range(0, 3) != 0)
          drive(1'b1, $urandom, USER_W'($urandom), 1'($urandom));
        else
          drive(1'b0, '0, '0, 1'b0);
      end
      m_tready = ($urandom_range(0, 2) != 0);
      step();
      cycles++;
    end
    chk("rand_timeout", 64'(cycles < 20000), 64'h1);
    chk("rand_out", 64'(out_cnt - base_out), 64'd1000);
    drive(1'b0, '0, '0, 1'b0);

    // mid-stream reset while FULL
    m_tready = 1'b0;
    drive(1'b1, $urandom, '0, 1'b0);
    step();
    drive(1'b1, $urandom, '0, 1'b1);
    step();
    chk("full_tready", 64'(s_tready), 64'h0);
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    step();
    chk("mid_rst_tvalid", 64'(m_tvalid), 64'h0);
    chk("mid_rst_tready", 64'(s_tready), 64'h0);
    rst = 1'b0;
    step();
    m_tready = 1'b1;
    drive(1'b1, 32'hA5A5A5A5, '0, 1'b1);
    step();
    chk("post_rst_tdata", 64'(m_tdata), 64'hA5A5A5A5);
    drive(1'b0, '0, '0, 1'b0);
    step();
    chk("post_rst_tvalid", 64'(m_tvalid), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
